// File: rtl/diagnosis_event_pkg.sv
// diagnosis_event_pkg: shared constants for the diagnosis event monitor
package diagnosis_event_pkg;
  localparam int CONF_FLITS_PER_CH = 5;
  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_IN    = 2'b01;
  localparam logic [1:0] MODE_OUT   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;
  localparam int FLIT_CTRL = 0;
  localparam int FLIT_LO_L = 1;
  localparam int FLIT_LO_H = 2;
  localparam int FLIT_HI_L = 3;
  localparam int FLIT_HI_H = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_DEC_LSB  = 3;
  localparam int CTRL_ID_LSB   = 8;
endpackage

// File: rtl/diagnosis_event_fifo.sv
// diagnosis_event_fifo: first-word-fall-through FIFO with full/empty flags
module diagnosis_event_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_wr, w_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  // a pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it
  assign w_wr    = i_push & (~o_full | w_rd);
  // head reads as zero when empty so outputs are clean after reset
  assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  // storage write
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  // read/write pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + {{AW{1'b0}}, w_wr};
      r_rd <= r_rd + {{AW{1'b0}}, w_rd};
    end
endmodule

// File: rtl/diagnosis_event_monitor.sv
// diagnosis_event_monitor: multi-channel PC comparator with decimation, pending stage, arbiter and event FIFO
module diagnosis_event_monitor
  import diagnosis_event_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int EV_ID_WIDTH = 8,
  parameter int TS_WIDTH    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     diag_sys_enabled,
  input  logic [16*CONF_FLITS_PER_CH*NUM_CH-1:0]   conf_flat_in,
  input  logic [31:0]                              pc_val,
  input  logic                                     pc_enable,
  input  logic [TS_WIDTH-1:0]                      time_global,
  output logic                                     ev_valid,
  output logic [EV_ID_WIDTH-1:0]                   ev_id,
  output logic [TS_WIDTH-1:0]                      ev_time,
  input  logic                                     ev_ready,
  output logic [15:0]                              drop_cnt
);
  localparam int EW = EV_ID_WIDTH + TS_WIDTH;
  logic [NUM_CH-1:0] w_pend, w_fire, w_grant, w_drop;
  logic [TS_WIDTH-1:0] w_ts [NUM_CH];
  logic [EV_ID_WIDTH-1:0] w_id [NUM_CH];
  logic w_full, w_empty, w_push, w_pop, w_can_push;
  logic [EW-1:0] w_wdata, w_rdata;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [15:0] w_ctrl;
    logic [31:0] w_lo, w_hi;
    logic [1:0] w_mode;
    logic [4:0] w_dec, r_cnt;
    logic w_active, w_cmp, w_match, r_pend;
    logic [TS_WIDTH-1:0] r_ts;
    assign w_ctrl   = conf_flat_in[16*(CONF_FLITS_PER_CH*c+FLIT_CTRL) +: 16];
    assign w_lo     = {conf_flat_in[16*(CONF_FLITS_PER_CH*c+FLIT_LO_H) +: 16], conf_flat_in[16*(CONF_FLITS_PER_CH*c+FLIT_LO_L) +: 16]};
    assign w_hi     = {conf_flat_in[16*(CONF_FLITS_PER_CH*c+FLIT_HI_H) +: 16], conf_flat_in[16*(CONF_FLITS_PER_CH*c+FLIT_HI_L) +: 16]};
    assign w_mode   = w_ctrl[CTRL_MODE_LSB +: 2];
    assign w_dec    = w_ctrl[CTRL_DEC_LSB +: 5];
    assign w_id[c]  = w_ctrl[CTRL_ID_LSB +: EV_ID_WIDTH];
    assign w_active = w_ctrl[CTRL_EN] & (w_mode != MODE_OFF);
    assign w_cmp    = w_mode == MODE_EXACT ? pc_val == w_lo :
                      w_mode == MODE_IN    ? (pc_val >= w_lo) && (pc_val <= w_hi) :
                                             (pc_val < w_lo) || (pc_val > w_hi);
    assign w_match  = diag_sys_enabled & pc_enable & w_active & w_cmp;
    // a count left above a freshly lowered dec fires on the next match rather than wrapping
    assign w_fire[c] = w_match & (r_cnt >= w_dec);
    assign w_drop[c] = w_fire[c] & r_pend & ~w_grant[c];
    assign w_pend[c] = r_pend;
    assign w_ts[c]   = r_ts;
    // decimator: count matches, fire and restart when the count reaches dec
    always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= '0;
      else if (!diag_sys_enabled || !w_active) r_cnt <= '0;
      else if (w_match) r_cnt <= w_fire[c] ? 5'd0 : r_cnt + 5'd1;
    // pending slot: set on fire (clear-then-set allowed), cleared when granted to the FIFO
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_pend <= 1'b0;
        r_ts   <= '0;
      end else if (!diag_sys_enabled) r_pend <= 1'b0;
      else if (w_fire[c] && !w_drop[c]) begin
        r_pend <= 1'b1;
        r_ts   <= time_global;
      end else if (w_grant[c]) r_pend <= 1'b0;
  end

  assign w_pop      = ev_valid & ev_ready;
  assign w_can_push = ~w_full | w_pop;
  assign w_push     = (|w_pend) & w_can_push;

  // fixed-priority arbiter: scanning downward leaves the lowest pending channel selected
  always_comb begin
    w_grant = '0;
    w_wdata = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_pend[i]) begin
        w_grant    = '0;
        w_grant[i] = w_can_push;
        w_wdata    = {w_id[i], w_ts[i]};
      end
  end

  // total drops this cycle added onto the running count
  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_CH; i++) w_drop_sum = w_drop_sum + {16'd0, w_drop[i]};
  end

  // saturating drop counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_drop <= '0;
    else r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  diagnosis_event_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .i_push (w_push),
    .i_data (w_wdata),
    .i_pop  (w_pop),
    .o_data (w_rdata),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign ev_valid         = ~w_empty;
  assign {ev_id, ev_time} = w_rdata;
  assign drop_cnt         = r_drop;
endmodule

// File: tb/tb_diagnosis_event_monitor.sv
// tb_diagnosis_event_monitor: directed table-driven checks of the event monitor
module tb_diagnosis_event_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic diag_sys_enabled = 1'b0;
  logic [319:0] conf = '0;
  logic [31:0] pc_val = '0;
  logic pc_enable = 1'b0;
  logic [31:0] time_global = 32'd0;
  logic ev_valid, ev_ready;
  logic [7:0] ev_id;
  logic [31:0] ev_time;
  logic [15:0] drop_cnt;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] ts;
    int          cyc;
  } ev_t;
  ev_t q[$];

  typedef struct {
    logic [31:0] pc;
    int          n;
    logic [7:0]  id0;
    logic [7:0]  id1;
  } vec_t;
  vec_t vt[5];

  diagnosis_event_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .diag_sys_enabled(diag_sys_enabled),
    .conf_flat_in    (conf),
    .pc_val          (pc_val),
    .pc_enable       (pc_enable),
    .time_global     (time_global),
    .ev_valid        (ev_valid),
    .ev_id           (ev_id),
    .ev_time         (ev_time),
    .ev_ready        (ev_ready),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    time_global <= time_global + 32'd1;
    cyc <= cyc + 1;
  end

  always @(negedge clk)
    if (rst && ev_valid && ev_ready) q.push_back('{id: ev_id, ts: ev_time, cyc: cyc});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic en, input logic [1:0] mode, input logic [4:0] dec,
                        input logic [7:0] id, input logic [31:0] lo, input logic [31:0] hi);
    conf[16*(5*c)   +: 16] = {id, dec, mode, en};
    conf[16*(5*c+1) +: 16] = lo[15:0];
    conf[16*(5*c+2) +: 16] = lo[31:16];
    conf[16*(5*c+3) +: 16] = hi[15:0];
    conf[16*(5*c+4) +: 16] = hi[31:16];
  endtask

  task automatic all_off();
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 2'b11, 5'd0, 8'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic burst(input logic [31:0] pc, input int n, output logic [31:0] t0);
    pc_val = pc;
    pc_enable = 1'b1;
    t0 = time_global;
    repeat (n) tick();
    pc_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    vt[0] = '{pc: 32'h1000, n: 2, id0: 8'd5, id1: 8'd2};
    vt[1] = '{pc: 32'h2000, n: 1, id0: 8'd1, id1: 8'd0};
    vt[2] = '{pc: 32'h20FF, n: 1, id0: 8'd1, id1: 8'd0};
    vt[3] = '{pc: 32'h2100, n: 1, id0: 8'd2, id1: 8'd0};
    vt[4] = '{pc: 32'h1FFF, n: 1, id0: 8'd2, id1: 8'd0};
    ev_ready = 1'b1;
    repeat (3) tick();
    check("reset ev_valid", ev_valid, 0);
    check("reset ev_id", ev_id, 0);
    check("reset ev_time", ev_time, 0);
    check("reset drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    diag_sys_enabled = 1'b1;
    tick();

    set_ch(0, 1'b1, 2'b00, 5'd0, 8'd5, 32'h1000, 32'h0);
    set_ch(1, 1'b1, 2'b01, 5'd0, 8'd1, 32'h2000, 32'h20FF);
    set_ch(2, 1'b1, 2'b10, 5'd0, 8'd2, 32'h2000, 32'h20FF);
    tick();

    burst(32'h1000, 1, t);
    check("exact latency N+1 ev_valid", ev_valid, 0);
    tick();
    check("exact ev_valid", ev_valid, 1);
    check("exact ev_id", ev_id, 5);
    check("exact ev_time", ev_time, t);
    repeat (5) tick();
    q.delete();

    for (int i = 0; i < 5; i++) begin
      q.delete();
      burst(vt[i].pc, 1, t);
      repeat (5) tick();
      check($sformatf("vec%0d count", i), q.size(), vt[i].n);
      if (q.size() >= 1) begin
        check($sformatf("vec%0d id0", i), q[0].id, vt[i].id0);
        check($sformatf("vec%0d ts0", i), q[0].ts, t);
      end
      if (q.size() >= 2) check($sformatf("vec%0d id1", i), q[1].id, vt[i].id1);
    end

    all_off();
    set_ch(0, 1'b1, 2'b00, 5'd2, 8'd7, 32'h3000, 32'h0);
    tick();
    q.delete();
    burst(32'h3000, 9, t);
    repeat (6) tick();
    check("decim count", q.size(), 3);
    if (q.size() == 3) begin
      check("decim ts0", q[0].ts, t + 2);
      check("decim ts1", q[1].ts, t + 5);
      check("decim ts2", q[2].ts, t + 8);
    end

    all_off();
    set_ch(0, 1'b1, 2'b00, 5'd0, 8'd10, 32'h4000, 32'h0);
    set_ch(1, 1'b1, 2'b01, 5'd0, 8'd11, 32'h4000, 32'h4000);
    set_ch(3, 1'b1, 2'b00, 5'd0, 8'd13, 32'h4000, 32'h0);
    tick();
    q.delete();
    burst(32'h4000, 1, t);
    repeat (6) tick();
    check("arb count", q.size(), 3);
    if (q.size() == 3) begin
      check("arb id0", q[0].id, 10);
      check("arb id1", q[1].id, 11);
      check("arb id2", q[2].id, 13);
      check("arb ts1", q[1].ts, t);
      check("arb ts2", q[2].ts, t);
      check("arb back-to-back 1", q[1].cyc, q[0].cyc + 1);
      check("arb back-to-back 2", q[2].cyc, q[1].cyc + 1);
    end

    all_off();
    set_ch(0, 1'b1, 2'b00, 5'd0, 8'd20, 32'h5000, 32'h0);
    tick();
    q.delete();
    ev_ready = 1'b0;
    burst(32'h5000, 10, t);
    repeat (2) tick();
    check("bp drop_cnt", drop_cnt, 1);
    check("bp ev_valid", ev_valid, 1);
    check("bp head id", ev_id, 20);
    check("bp head time", ev_time, t);
    tick();
    check("bp head time stable", ev_time, t);
    ev_ready = 1'b1;
    repeat (14) tick();
    check("bp delivered", q.size(), 9);
    if (q.size() == 9) begin
      check("bp first ts", q[0].ts, t);
      check("bp last ts", q[8].ts, t + 8);
    end
    check("bp drop_cnt after", drop_cnt, 1);

    q.delete();
    ev_ready = 1'b0;
    burst(32'h5000, 9, t);
    repeat (2) tick();
    check("dis ev_valid", ev_valid, 1);
    diag_sys_enabled = 1'b0;
    repeat (2) tick();
    ev_ready = 1'b1;
    repeat (12) tick();
    diag_sys_enabled = 1'b1;
    repeat (4) tick();
    check("dis drained count", q.size(), 8);
    check("dis ev_valid after", ev_valid, 0);
    check("dis drop_cnt", drop_cnt, 1);

    ev_ready = 1'b0;
    burst(32'h5000, 3, t);
    repeat (3) tick();
    ev_ready = 1'b1;
    tick();
    check("rst pre ev_valid", ev_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("rst async ev_valid", ev_valid, 0);
    check("rst async ev_id", ev_id, 0);
    check("rst async ev_time", ev_time, 0);
    check("rst async drop_cnt", drop_cnt, 0);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("rst post ev_valid", ev_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
